scroll_controller: RTL

- Sequencer for the word-rotation datapath (shift_word and its character output).
- Replaces the free-running 1 s tick with a controlled shift strobe. Supports start, pause, resume, stop and single-step, a selectable scroll speed, and direction sampled per shift.
- Tracks the rotation position so higher-level logic knows which character leads.
- Sits between the board buttons/switches (already debounced and synchronised) and shift_word.

---
 rtl/scroll_pkg.sv | 27 ++
 rtl/scroll_controller_tick_prescaler.sv | 48 ++++
 rtl/scroll_controller.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/scroll_pkg.sv
// Shared definitions for the scroll controller: FSM state codes, direction
// encodings and the bit-width helper used to size counters and the pos output.
package scroll_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2
  } state_e;

  localparam logic DIR_LEFT  = 1'b1;
  localparam logic DIR_RIGHT = 1'b0;

  // Number of bits needed to hold the value v (at least 1).
  function automatic int unsigned clogb2(input int unsigned v);
    int unsigned n;
    int unsigned x;
    n = 0;
    x = v;
    while (x > 0) begin
      n = n + 1;
      x = x >> 1;
    end
    return (n == 0) ? 1 : n;
  endfunction

endpackage

// File: rtl/scroll_controller_tick_prescaler.sv
// Period counter for RUN timing: counts 0..period-1, flags the terminal count
// and reloads its period register at each terminal count or on an explicit load.
module tick_prescaler
  import scroll_pkg::*;
#(
  parameter int unsigned PER_W      = 26,
  parameter int unsigned RST_PERIOD = 50000000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  input  logic             load,
  input  logic [PER_W-1:0] period_in,
  output logic             tc_c
);

  logic [PER_W-1:0] cnt_q, cnt_d;
  logic [PER_W-1:0] period_q, period_d;

  assign tc_c = (cnt_q == (period_q - PER_W'(1)));

  // Next count and period; clear wins over enable.
  always_comb begin
    cnt_d    = cnt_q;
    period_d = period_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = tc_c ? '0 : (cnt_q + PER_W'(1));
    end
    if (load || (en && !clr && tc_c)) begin
      period_d = period_in;
    end
  end

  // Counter and period registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      period_q <= PER_W'(RST_PERIOD);
    end else begin
      cnt_q    <= cnt_d;
      period_q <= period_d;
    end
  end

endmodule

// File: rtl/scroll_controller.sv
// Shift-strobe sequencer for the word-rotation datapath. Handles start, pause,
// resume, stop and single-step, selectable period (TICK_M >> speed) and tracks
// the rotation position.
// Optional build macro SCROLL_AUTOSTOP_EN: stop automatically after WORD_LEN
// timed shifts and pulse the done output.
module scroll_controller
  import scroll_pkg::*;
#(
  parameter int unsigned TICK_M   = 50000000,
  parameter int unsigned WORD_LEN = 8,
  parameter int unsigned POS_W    = clogb2(WORD_LEN - 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             pause,
  input  logic             stop,
  input  logic             step,
  input  logic             direction,
  input  logic [1:0]       speed,
  output logic             shift_en,
  output logic             shift_dir,
  output logic [POS_W-1:0] pos,
`ifdef SCROLL_AUTOSTOP_EN
  output logic             done,
`endif
  output logic             busy,
  output logic [1:0]       state
);

  localparam int unsigned PER_W = clogb2(TICK_M);

  state_e           state_q, state_d;
  logic             shift_en_q, shift_en_d;
  logic             shift_dir_q, shift_dir_d;
  logic [POS_W-1:0] pos_q, pos_d;
  logic             busy_q, busy_d;

  logic             ps_clr, ps_en, ps_load, ps_tc_c;
  logic             do_shift;
  logic [PER_W-1:0] period_sel;

`ifdef SCROLL_AUTOSTOP_EN
  localparam int unsigned SC_W = clogb2(WORD_LEN);
  logic [SC_W-1:0]  sc_q, sc_d;
  logic             done_q, done_d;
`endif

  assign period_sel = PER_W'(TICK_M) >> speed;

  tick_prescaler #(
    .PER_W      (PER_W),
    .RST_PERIOD (TICK_M)
  ) u_prescaler (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (ps_clr),
    .en        (ps_en),
    .load      (ps_load),
    .period_in (period_sel),
    .tc_c      (ps_tc_c)
  );

  // Next-state, prescaler control and shift/position update.
  always_comb begin
    state_d     = state_q;
    shift_en_d  = 1'b0;
    shift_dir_d = shift_dir_q;
    pos_d       = pos_q;
    ps_clr      = 1'b0;
    ps_en       = 1'b0;
    ps_load     = 1'b0;
    do_shift    = 1'b0;
`ifdef SCROLL_AUTOSTOP_EN
    sc_d        = sc_q;
    done_d      = 1'b0;
`endif

    if (stop) begin
      state_d = ST_IDLE;
      pos_d   = '0;
      ps_clr  = 1'b1;
`ifdef SCROLL_AUTOSTOP_EN
      sc_d    = '0;
`endif
    end else begin
      case (state_q)
        ST_RUN: begin
`ifdef SCROLL_AUTOSTOP_EN
          if (sc_q == SC_W'(WORD_LEN)) begin
            // Full revolution completed on the previous edge.
            state_d = ST_IDLE;
            done_d  = 1'b1;
            sc_d    = '0;
            ps_clr  = 1'b1;
          end else begin
`endif
            // A terminal count still shifts even when pause arrives with it.
            ps_en = ps_tc_c || !pause;
            if (ps_tc_c) begin
              do_shift = 1'b1;
`ifdef SCROLL_AUTOSTOP_EN
              sc_d     = sc_q + SC_W'(1);
`endif
            end
            if (pause) begin
              state_d = ST_PAUSE;
            end
`ifdef SCROLL_AUTOSTOP_EN
          end
`endif
        end
        ST_PAUSE: begin
          if (start) begin
            state_d = ST_RUN;
          end else if (step) begin
            do_shift = 1'b1;
          end
        end
        default: begin
          // ST_IDLE and the unused code 2'd3.
          state_d = ST_IDLE;
          if (start) begin
            state_d = ST_RUN;
            ps_clr  = 1'b1;
            ps_load = 1'b1;
          end else if (step) begin
            do_shift = 1'b1;
          end
        end
      endcase
    end

    if (do_shift) begin
      shift_en_d  = 1'b1;
      shift_dir_d = direction;
      if (direction == DIR_RIGHT) begin
        pos_d = (pos_q == '0) ? POS_W'(WORD_LEN - 1) : (pos_q - POS_W'(1));
      end else begin
        pos_d = (pos_q == POS_W'(WORD_LEN - 1)) ? '0 : (pos_q + POS_W'(1));
      end
    end
  end

  assign busy_d = (state_d == ST_RUN);

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      shift_en_q  <= 1'b0;
      shift_dir_q <= DIR_LEFT;
      pos_q       <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      shift_en_q  <= shift_en_d;
      shift_dir_q <= shift_dir_d;
      pos_q       <= pos_d;
      busy_q      <= busy_d;
    end
  end

`ifdef SCROLL_AUTOSTOP_EN
  // Timed-shift counter and done pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sc_q   <= '0;
      done_q <= 1'b0;
    end else begin
      sc_q   <= sc_d;
      done_q <= done_d;
    end
  end

  assign done = done_q;
`endif

  assign shift_en  = shift_en_q;
  assign shift_dir = shift_dir_q;
  assign pos       = pos_q;
  assign busy      = busy_q;
  assign state     = state_q;

endmodule
